// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: immediate / load-data extension to XLEN bits,
// registered behind a valid/ready handshake with a 2-entry skid buffer.
module ext_unit_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_word,
  input  logic [2:0]           in_mode,
  input  logic [1:0]           in_off,
  input  logic                 in_uns,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_data,
  output logic                 out_misalign,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic [31:0]          r32;
  logic                 e;
  logic                 mis;
  logic [7:0]           lb;
  logic [15:0]          lh;
  logic [XLEN-1:0]      x;

  logic                 m_valid;
  logic [XLEN-1:0]      m_data;
  logic                 m_mis;
  logic [TAG_WIDTH-1:0] m_tag;
  logic                 k_valid;
  logic [XLEN-1:0]      k_data;
  logic                 k_mis;
  logic [TAG_WIDTH-1:0] k_tag;
  logic                 rdy;
  logic                 acc;
  logic                 drn;

  // Field unpack and extension up to 32 bits; e carries the fill bit.
  always_comb begin
    r32 = '0;
    e   = 1'b0;
    mis = 1'b0;
    lb  = '0;
    lh  = '0;
    unique case (in_off)
      2'd0: lb = in_word[7:0];
      2'd1: lb = in_word[15:8];
      2'd2: lb = in_word[23:16];
      2'd3: lb = in_word[31:24];
    endcase
    lh = in_off[1] ? in_word[31:16] : in_word[15:0];
    unique case (in_mode)
      3'd0: begin
        e   = ~in_uns & in_word[31];
        r32 = {{20{e}}, in_word[31:20]};
      end
      3'd1: begin
        e   = ~in_uns & in_word[31];
        r32 = {{20{e}}, in_word[31:25],
               in_word[11:7]};
      end
      3'd2: begin
        e   = ~in_uns & in_word[31];
        r32 = {{19{e}}, in_word[31], in_word[7],
               in_word[30:25], in_word[11:8],
               1'b0};
      end
      3'd3: begin
        e   = ~in_uns & in_word[31];
        r32 = {in_word[31:12], 12'b0};
      end
      3'd4: begin
        e   = ~in_uns & in_word[31];
        r32 = {{11{e}}, in_word[31],
               in_word[19:12], in_word[20],
               in_word[30:21], 1'b0};
      end
      3'd5: begin
        e   = ~in_uns & lb[7];
        r32 = {{24{e}}, lb};
      end
      3'd6: begin
        mis = in_off[0];
        e   = ~in_uns & lh[15] & ~mis;
        r32 = mis ? '0 : {{16{e}}, lh};
      end
      3'd7: begin
        mis = (in_off != 2'd0);
        e   = ~in_uns & in_word[31] & ~mis;
        r32 = mis ? '0 : in_word;
      end
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign x = {{(XLEN-32){e}}, r32};
    end else begin : g_narrow
      assign x = r32;
    end
  endgenerate

  assign acc = in_valid && rdy;
  assign drn = m_valid && out_ready;

  // Main/skid registers; K only fills when M stalls, refills M on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_mis   <= 1'b0;
      m_tag   <= '0;
      k_valid <= 1'b0;
      k_data  <= '0;
      k_mis   <= 1'b0;
      k_tag   <= '0;
      rdy     <= 1'b1;
    end else if (k_valid) begin
      if (drn) begin
        m_data  <= k_data;
        m_mis   <= k_mis;
        m_tag   <= k_tag;
        k_valid <= 1'b0;
        rdy     <= 1'b1;
      end
    end else if (acc) begin
      if (!m_valid || drn) begin
        m_valid <= 1'b1;
        m_data  <= x;
        m_mis   <= mis;
        m_tag   <= in_tag;
      end else begin
        k_valid <= 1'b1;
        k_data  <= x;
        k_mis   <= mis;
        k_tag   <= in_tag;
        rdy     <= 1'b0;
      end
    end else if (drn) begin
      m_valid <= 1'b0;
    end
  end

  assign in_ready     = rdy;
  assign out_valid    = m_valid;
  assign out_data     = m_data;
  assign out_misalign = m_mis;
  assign out_tag      = m_tag;

endmodule

// File: doc/ext_unit_pipe.md
# ext_unit_pipe

Parametrised, pipelined extension unit for the RISC-V datapath. It unpacks and extends the immediate of every base format (I/S/B/U/J) and the sign/zero-extension of load data (byte/half/word with byte offset) to XLEN bits. The result is registered behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between decode and execute, or between memory return and writeback, without a combinational ready path.

## Interface
- XLEN, 32: output width; legal values ≥ 32 (32 or 64 in practice).
- TAG_WIDTH, 5: width of the sideband tag (e.g. rd index), carried unchanged with each result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit can accept; driven directly from a register.
- in_word  in  32  instruction word (immediate modes) or loaded memory word (load modes).
- in_mode  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=LOAD_B, 6=LOAD_H, 7=LOAD_W.
- in_off  in  2  byte offset; load modes only.
- in_uns  in  1  1 = zero-extend, 0 = sign-extend.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  XLEN  extended value.
- out_misalign  out  1  load offset illegal for the mode.
- out_tag  out  TAG_WIDTH  tag of this result.

## Operation
- Raw field R of width W, taken from in_word. Brackets below are bit indices of in_word:
  - I: [31:20], W=12.
  - S: {[31:25],[11:7]}, W=12.
  - B: {[31],[7],[30:25],[11:8],0}, W=13.
  - U: {[31:12],12'b0}, W=32.
  - J: {[31],[19:12],[20],[30:21],0}, W=21.
  - LOAD_B: byte at 8·in_off, W=8.
  - LOAD_H: half at 16·in_off[1], W=16.
  - LOAD_W: whole word, W=32.
- Extension: out_data = {(XLEN−W) copies of E, R}, where E = in_uns ? 0 : R[W−1]. in_uns applies in every mode.
- Misalignment:
  - LOAD_H with in_off[0]=1 → out_misalign=1, out_data=0.
  - LOAD_W with in_off≠0 → out_misalign=1, out_data=0.
  - All other cases: out_misalign=0. in_off is ignored outside load modes.
- Storage: main output register M (drives out_*) plus skid register K. in_ready = !K_valid.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Next-state rules at each edge:
  - Accept, M empty or draining, K empty → result into M.
  - Accept, M full and not draining → result into K.
  - Drain with K full → K moves to M, K becomes empty. No accept is possible in this cycle because in_ready=0.
  - Drain with K empty and no accept → M becomes empty.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- Inputs are sampled only on accept. Input changes while in_ready=0 have no effect.

## Timing
- Latency: an input accepted at edge k appears on out_* immediately after edge k.
- Throughput: 1 per cycle while out_ready=1.
- in_ready falls in the cycle after a result is written into K, and rises in the cycle after K drains.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_misalign and out_tag hold their values.
- Reset values, asynchronous on rst_n falling and held while rst_n=0:
  - out_valid=0, out_data=0, out_misalign=0, out_tag=0.
  - K_valid=0, in_ready=1.
- Reset mid-operation discards both M and K immediately.
- No transaction is accepted while rst_n=0. The first accept is possible at the first rising edge after rst_n=1.
- Simultaneous accept and drain with K empty: M is replaced by the new result and out_valid stays 1.

## Test plan
- I/S modes, XLEN=32:
  - in_word=0xFFF00093, mode 0, uns 0 → out_data=0xFFFFFFFF one cycle later.
  - Same word with uns 1 → 0x00000FFF.
  - S-type sw with offset −8 → 0xFFFFFFF8.
- B/J modes:
  - 0xFE000EE3, mode 2 → 0xFFFFFFFC.
  - 0x0010006F, mode 4 → 0x00000800.
- Load modes, in_word=0x80FF7F01:
  - LOAD_B, off 2, uns 0 → 0xFFFFFFFF.
  - LOAD_B, off 3, uns 1 → 0x00000080.
  - LOAD_H, off 2, uns 0 → 0xFFFF80FF.
  - LOAD_H, off 1 → out_misalign=1, out_data=0.
  - LOAD_W, off 0 → 0x80FF7F01.
- Backpressure:
  - Hold out_ready=0 and offer tags 1,2,3 back-to-back.
  - Tag 1 lands in M, tag 2 in K, in_ready=0 the cycle after; tag 3 waits.
  - Raise out_ready: outputs appear as 1,2,3 on consecutive cycles, in_ready returns to 1, and out_* stay stable during the stall.
- Reset mid-operation: with M and K full, pulse rst_n low between edges → out_valid=0 and in_ready=1 without waiting for a clock edge; after release, a fresh accept behaves normally.
- XLEN=64: U mode, 0x800000B7 → 0xFFFFFFFF80000000; with uns 1 → 0x0000000080000000.
